// File: rtl/regfile_scoreboard.sv
// 32x32 register file with busy-bit scoreboard and combinational operand reads.
// Optional same-cycle write-back bypass: define REGFILE_WB_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_dst,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_dst,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int N = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [N];
    logic [N-1:0]      r_busy;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_rs_reiss;
    logic w_rt_reiss;
    logic w_rs_stall;
    logic w_rt_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (wb_valid && (wb_dst != '0)) begin
                r_regs[wb_dst] <= wb_data;
            end
            // A new producer issued in the same cycle as a write-back keeps the bit set.
            for (int i = 1; i < N; i++) begin
                if (iss_valid && (iss_dst == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (wb_valid && (wb_dst == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign w_rs_hit = wb_valid && (wb_dst == rs_addr) && (rs_addr != '0);
    assign w_rt_hit = wb_valid && (wb_dst == rt_addr) && (rt_addr != '0);
`else
    assign w_rs_hit = 1'b0;
    assign w_rt_hit = 1'b0;
`endif

    assign w_rs_reiss = iss_valid && (iss_dst == rs_addr);
    assign w_rt_reiss = iss_valid && (iss_dst == rt_addr);

    // A bypassed source only stalls if it is being re-issued this same cycle.
    assign w_rs_stall = (rs_addr != '0) && (w_rs_hit ? w_rs_reiss : r_busy[rs_addr]);
    assign w_rt_stall = (rt_addr != '0) && (w_rt_hit ? w_rt_reiss : r_busy[rt_addr]);

    assign stall    = w_rs_stall || w_rt_stall;
    assign busy_vec = r_busy;

    always_comb begin
        rs_data = r_regs[rs_addr];
        rt_data = r_regs[rt_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (w_rs_hit) begin
            rs_data = wb_data;
        end
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (w_rt_hit) begin
            rt_data = wb_data;
        end
    end

endmodule
